instr_fifo: RTL and testbench

INSTR_FIFO -- requirements
Module: instr_fifo

---
 rtl/instr_fifo.sv | 151 +++++++++++++++
 tb/tb_instr_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fifo.sv
// ---------------------------------------------------------------------------
// instr_fifo
//
// Purpose:
//   Instruction queue between a host writer and the X-HEEP instruction
//   consumer. Entries come out in order with a valid/ready handshake. A push
//   becomes visible on the read side one cycle after it is accepted. There is
//   no same-cycle bypass from instr_in to instr_out. DEPTH may be any integer
//   >= 2. The pointers wrap explicitly and do not rely on power-of-two
//   overflow.
//
// Parameters:
//   DATA_WIDTH  instruction word width in bits (>= 1)
//   DEPTH       number of entries (>= 2)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset (beats flush, push and pop)
//   flush        synchronous clear of all queued entries (beats push and pop)
//   push         host write strobe
//   instr_in     instruction to enqueue
//   push_ready   high when a push would be accepted this cycle (!full)
//   instr_valid  head entry available (!empty)
//   instr_ready  consumer takes the head when high together with instr_valid
//   instr_out    head instruction, all-zeros while empty
//   count        number of stored entries
//   full, empty  count == DEPTH, count == 0
//
// Optional feature (define INSTR_FIFO_ERR_FLAG_EN):
//   ovf_err      sticky flag, set by a push while full
//   err_clr      clears ovf_err (a set in the same cycle wins)
// ---------------------------------------------------------------------------
module instr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic                  push_ready,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
`ifdef INSTR_FIFO_ERR_FLAG_EN
    ,
    output logic                  ovf_err,
    input  logic                  err_clr
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    // Storage is not reset. Nothing can read it while count is zero, so a
    // stale word never reaches instr_out.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    // Status flags and the handshake decisions come only from registered
    // state, so instr_valid and push_ready never depend on their own
    // handshake partner. This also rules out a bypass on an empty queue.
    always_comb begin
        full        = (count_q == DEPTH_CNT);
        empty       = (count_q == '0);
        push_ready  = !full;
        instr_valid = !empty;
        do_push     = push && push_ready;
        do_pop      = instr_valid && instr_ready;
        count       = count_q;
        instr_out   = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Next-state logic for the pointers and the occupancy counter. Flush
    // discards everything and masks any push or pop in the same cycle. A
    // simultaneous push and pop moves both pointers and leaves count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register. Reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data write. The write is suppressed during reset and flush so that a
    // discarded push never touches the array.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem_q[wr_ptr_q] <= instr_in;
        end
    end

`ifdef INSTR_FIFO_ERR_FLAG_EN
    logic ovf_err_q;

    // Sticky overflow flag. A rejected push sets it even during a flush.
    // A set in the same cycle as err_clr wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
        end else if (push && full) begin
            ovf_err_q <= 1'b1;
        end else if (err_clr) begin
            ovf_err_q <= 1'b0;
        end
    end

    assign ovf_err = ovf_err_q;
`endif

endmodule

// File: tb/tb_instr_fifo.sv
// ---------------------------------------------------------------------------
// tb_instr_fifo
//
// Purpose:
//   Self-checking bench for instr_fifo with DATA_WIDTH=32 and DEPTH=4. The
//   expected behaviour comes from a queue-based reference model. The bench
//   runs directed scenarios and then a randomized run.
//   If INSTR_FIFO_ERR_FLAG_EN is defined, it also checks ovf_err.
// ---------------------------------------------------------------------------
module tb_instr_fifo;

    localparam int DW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] instr_in = '0;
    logic          push_ready;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_out;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          err_clr = 1'b0;
`ifdef INSTR_FIFO_ERR_FLAG_EN
    logic          ovf_err;
`endif

    logic [DW-1:0] refQ[$];
    logic          refErr = 1'b0;
    int            nChecks = 0;
    int            nFails = 0;

    instr_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (push),
        .instr_in    (instr_in),
        .push_ready  (push_ready),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .count       (count),
        .full        (full),
        .empty       (empty)
`ifdef INSTR_FIFO_ERR_FLAG_EN
        ,
        .ovf_err     (ovf_err),
        .err_clr     (err_clr)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, advance the reference
    // model with the same inputs, then release the strobes 1ns after the edge.
    task automatic applyStimulus(input logic p, input logic [DW-1:0] d,
                                 input logic r, input logic f,
                                 input logic rs, input logic ec);
        logic wasFull;
        logic canPop;
        push        = p;
        instr_in    = d;
        instr_ready = r;
        flush       = f;
        rst         = rs;
        err_clr     = ec;
        @(posedge clk);
        wasFull = (refQ.size() == DP);
        canPop  = (refQ.size() > 0) && r;
        if (rs) begin
            refQ.delete();
            refErr = 1'b0;
        end else begin
            if (p && wasFull) refErr = 1'b1;
            else if (ec) refErr = 1'b0;
            if (f) begin
                refQ.delete();
            end else begin
                if (canPop) void'(refQ.pop_front());
                if (p && !wasFull) refQ.push_back(d);
            end
        end
        #1;
        push = 1'b0; flush = 1'b0; rst = 1'b0; err_clr = 1'b0; instr_ready = 1'b0;
    endtask

    // Reset drives every output to its idle value.
    task automatic test_reset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        nChecks++; if (count !== 3'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
        nChecks++; if (full !== 1'b0) begin nFails++; $display("[TB] FAIL reset_full: got %b want 0", full); end
        nChecks++; if (instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
        nChecks++; if (push_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_push_ready: got %b want 1", push_ready); end
        nChecks++; if (instr_out !== 32'h0) begin nFails++; $display("[TB] FAIL reset_out: got %h want 0", instr_out); end
`ifdef INSTR_FIFO_ERR_FLAG_EN
        nChecks++; if (ovf_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf_err); end
`endif
    endtask

    // Fill the queue with no consumer. The head must stay at 0x11 throughout.
    task automatic test_fill();
        logic [DW-1:0] vals[4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, vals[i], 1'b0, 1'b0, 1'b0, 1'b0);
            nChecks++; if (instr_out !== 32'h11) begin nFails++; $display("[TB] FAIL fill_head_hold[%0d]: got %h want 11", i, instr_out); end
        end
        nChecks++; if (count !== 3'd4) begin nFails++; $display("[TB] FAIL fill_count: got %0d want 4", count); end
        nChecks++; if (full !== 1'b1) begin nFails++; $display("[TB] FAIL fill_full: got %b want 1", full); end
        nChecks++; if (push_ready !== 1'b0) begin nFails++; $display("[TB] FAIL fill_push_ready: got %b want 0", push_ready); end
        nChecks++; if (instr_valid !== 1'b1) begin nFails++; $display("[TB] FAIL fill_valid: got %b want 1", instr_valid); end
    endtask

    // A push into a full queue is dropped. Draining returns the original order.
    task automatic test_overflow();
        logic [DW-1:0] vals[4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (count !== 3'd4) begin nFails++; $display("[TB] FAIL ovf_count: got %0d want 4", count); end
`ifdef INSTR_FIFO_ERR_FLAG_EN
        nChecks++; if (ovf_err !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_set: got %b want 1", ovf_err); end
        applyStimulus(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (ovf_err !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_set_beats_clr: got %b want 1", ovf_err); end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (ovf_err !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_clear: got %b want 0", ovf_err); end
`endif
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (instr_out !== vals[i]) begin nFails++; $display("[TB] FAIL drain_order[%0d]: got %h want %h", i, instr_out, vals[i]); end
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("[TB] FAIL drain_empty: got %b want 1", empty); end
        nChecks++; if (instr_out !== 32'h0) begin nFails++; $display("[TB] FAIL drain_out_zero: got %h want 0", instr_out); end
    endtask

    // Run six simultaneous push/pop cycles at count 2 so both pointers wrap.
    task automatic test_wrap();
        logic [DW-1:0] expQ[$];
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0); expQ.push_back(32'hB0);
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b0); expQ.push_back(32'hB1);
        for (int i = 0; i < 6; i++) begin
            d = $urandom();
            want = expQ.pop_front();
            expQ.push_back(d);
            nChecks++; if (instr_out !== want) begin nFails++; $display("[TB] FAIL wrap_order[%0d]: got %h want %h", i, instr_out, want); end
            applyStimulus(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
            nChecks++; if (count !== 3'd2) begin nFails++; $display("[TB] FAIL wrap_count[%0d]: got %0d want 2", i, count); end
        end
        for (int i = 0; i < 2; i++) begin
            want = expQ.pop_front();
            nChecks++; if (instr_out !== want) begin nFails++; $display("[TB] FAIL wrap_tail[%0d]: got %h want %h", i, instr_out, want); end
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // On an empty queue, a push with instr_ready high only enqueues.
    // There is no bypass to the read side.
    task automatic test_empty_edge();
        nChecks++; if (instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL edge_pre_valid: got %b want 0", instr_valid); end
        applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        nChecks++; if (instr_valid !== 1'b1) begin nFails++; $display("[TB] FAIL edge_valid: got %b want 1", instr_valid); end
        nChecks++; if (instr_out !== 32'hA5) begin nFails++; $display("[TB] FAIL edge_out: got %h want a5", instr_out); end
        nChecks++; if (count !== 3'd1) begin nFails++; $display("[TB] FAIL edge_count: got %0d want 1", count); end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("[TB] FAIL edge_pop_empty: got %b want 1", empty); end
    endtask

    // Flush at count 3 wins over a push in the same cycle.
    task automatic test_flush();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hD1 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (count !== 3'd3) begin nFails++; $display("[TB] FAIL flush_pre_count: got %0d want 3", count); end
        applyStimulus(1'b1, 32'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
        nChecks++; if (count !== 3'd0) begin nFails++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("[TB] FAIL flush_empty: got %b want 1", empty); end
        nChecks++; if (instr_out !== 32'h0) begin nFails++; $display("[TB] FAIL flush_out: got %h want 0", instr_out); end
        applyStimulus(1'b1, 32'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (instr_out !== 32'h3C) begin nFails++; $display("[TB] FAIL flush_refill: got %h want 3c", instr_out); end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset in the middle of traffic discards all entries.
    // A later push shows up after one cycle.
    task automatic test_rst_midstream();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hF0 + i, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBAD, 1'b1, 1'b1, 1'b1, 1'b0);
        nChecks++; if (count !== 3'd0) begin nFails++; $display("[TB] FAIL rst_mid_count: got %0d want 0", count); end
        nChecks++; if (instr_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_valid: got %b want 0", instr_valid); end
        nChecks++; if (push_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rst_mid_push_ready: got %b want 1", push_ready); end
        nChecks++; if (instr_out !== 32'h0) begin nFails++; $display("[TB] FAIL rst_mid_out: got %h want 0", instr_out); end
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (instr_valid !== 1'b1) begin nFails++; $display("[TB] FAIL rst_push_valid: got %b want 1", instr_valid); end
        nChecks++; if (instr_out !== 32'h7) begin nFails++; $display("[TB] FAIL rst_push_out: got %h want 7", instr_out); end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Randomized traffic compared against the queue model after every edge.
    task automatic test_random();
        logic p, r, f, rs, ec;
        logic [DW-1:0] wantOut;
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 99) < 60);
            r  = ($urandom_range(0, 99) < 45);
            f  = ($urandom_range(0, 99) < 4);
            rs = ($urandom_range(0, 99) < 2);
            ec = ($urandom_range(0, 99) < 10);
            applyStimulus(p, $urandom(), r, f, rs, ec);
            wantOut = (refQ.size() > 0) ? refQ[0] : '0;
            nChecks++; if (count !== 3'(refQ.size())) begin nFails++; $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", i, count, refQ.size()); end
            nChecks++; if (instr_out !== wantOut) begin nFails++; $display("[TB] FAIL rand_out[%0d]: got %h want %h", i, instr_out, wantOut); end
            nChecks++; if (instr_valid !== (refQ.size() > 0)) begin nFails++; $display("[TB] FAIL rand_valid[%0d]: got %b", i, instr_valid); end
            nChecks++; if (full !== (refQ.size() == DP)) begin nFails++; $display("[TB] FAIL rand_full[%0d]: got %b", i, full); end
            nChecks++; if (empty !== (refQ.size() == 0)) begin nFails++; $display("[TB] FAIL rand_empty[%0d]: got %b", i, empty); end
            nChecks++; if (push_ready !== (refQ.size() != DP)) begin nFails++; $display("[TB] FAIL rand_push_ready[%0d]: got %b", i, push_ready); end
`ifdef INSTR_FIFO_ERR_FLAG_EN
            nChecks++; if (ovf_err !== refErr) begin nFails++; $display("[TB] FAIL rand_ovf[%0d]: got %b want %b", i, ovf_err, refErr); end
`endif
        end
    endtask

    // Run the scenarios in order, then print the summary.
    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_empty_edge();
        test_flush();
        test_rst_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
